// File: rtl/design_sel_pkg.sv
// Shared types and constants for the integrated-designs select sequencer.
package design_sel_pkg;

  localparam int unsigned SEL_W           = 4;
  localparam int unsigned NUM_DESIGNS_MAX = 12;
  localparam int unsigned STATE_W         = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    RESET  = 2'd2,
    ACTIVE = 2'd3
  } state_e;

  // Larger of two phase lengths; sizes the shared phase timer.
  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sel_phase_timer.sv
// Loadable down-counter timing the DRAIN and RESET phases of a switchover.
module sel_phase_timer #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire_c
);

  logic [W-1:0] count_q;

  // Load on phase entry, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (count_q != '0) begin
      count_q <= count_q - W'(1);
    end
  end

  // High during the last cycle of the current phase.
  assign expire_c = (count_q == W'(1));

endmodule

// File: rtl/design_select_sequencer.sv
// Drives design_select / design_n_rst for the integrated-designs mux with a
// park-on-zero, hold-in-reset, then release switchover sequence.
module design_select_sequencer
  import design_sel_pkg::*;
#(
  parameter int unsigned NUM_DESIGNS  = NUM_DESIGNS_MAX,
  parameter int unsigned GUARD_CYCLES = 4,
  parameter int unsigned RESET_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [3:0] req_sel,
  output logic       req_ready,
  output logic [3:0] design_select,
  output logic       design_n_rst,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] cur_sel
);

  localparam int unsigned TIMER_W = $clog2(max_u(GUARD_CYCLES, RESET_CYCLES) + 1);

  localparam logic [STATE_W-1:0] ST_IDLE   = IDLE;
  localparam logic [STATE_W-1:0] ST_DRAIN  = DRAIN;
  localparam logic [STATE_W-1:0] ST_RESET  = RESET;
  localparam logic [STATE_W-1:0] ST_ACTIVE = ACTIVE;

  localparam logic [SEL_W-1:0]   MAX_SEL   = SEL_W'(NUM_DESIGNS);
  localparam logic [TIMER_W-1:0] GUARD_LD  = TIMER_W'(GUARD_CYCLES);
  localparam logic [TIMER_W-1:0] RESET_LD  = TIMER_W'(RESET_CYCLES);

  logic [STATE_W-1:0] state_q, state_d;
  logic [SEL_W-1:0]   target_q, target_d;
  logic [SEL_W-1:0]   select_d, cur_sel_d;
  logic               n_rst_d, busy_d, done_d, err_d, ready_d;
  logic               tmr_load_c;
  logic [TIMER_W-1:0] tmr_val_c;
  logic               tmr_expire_c;
  logic               accept_c;

  assign accept_c = req_valid && req_ready;

  sel_phase_timer #(
    .W(TIMER_W)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load_c),
    .load_val (tmr_val_c),
    .expire_c (tmr_expire_c)
  );

  // State, captured target and all outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      design_select <= '0;
      design_n_rst  <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      cur_sel       <= '0;
      req_ready     <= 1'b1;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      design_select <= select_d;
      design_n_rst  <= n_rst_d;
      busy          <= busy_d;
      done          <= done_d;
      err           <= err_d;
      cur_sel       <= cur_sel_d;
      req_ready     <= ready_d;
    end
  end

  // Next-state and next-output decode for the switchover sequence.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    select_d   = design_select;
    n_rst_d    = design_n_rst;
    busy_d     = busy;
    done_d     = 1'b0;
    err_d      = 1'b0;
    cur_sel_d  = cur_sel;
    tmr_load_c = 1'b0;
    tmr_val_c  = '0;

    case (state_q)
      ST_IDLE, ST_ACTIVE: begin
        if (accept_c) begin
          if (req_sel > MAX_SEL) begin
            // Out-of-range select: reject, leave the running design alone.
            err_d = 1'b1;
          end else begin
            target_d   = req_sel;
            state_d    = ST_DRAIN;
            select_d   = '0;
            n_rst_d    = 1'b0;
            busy_d     = 1'b1;
            tmr_load_c = 1'b1;
            tmr_val_c  = GUARD_LD;
          end
        end
      end
      ST_DRAIN: begin
        if (tmr_expire_c) begin
          if (target_q == '0) begin
            state_d   = ST_IDLE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            cur_sel_d = '0;
          end else begin
            // Apply the new select while the design is still held in reset.
            state_d    = ST_RESET;
            select_d   = target_q;
            tmr_load_c = 1'b1;
            tmr_val_c  = RESET_LD;
          end
        end
      end
      ST_RESET: begin
        if (tmr_expire_c) begin
          state_d   = ST_ACTIVE;
          n_rst_d   = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          cur_sel_d = target_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    ready_d = (state_d == ST_IDLE) || (state_d == ST_ACTIVE);
  end

endmodule

// File: tb/tb_design_select_sequencer.sv
// Directed, table-driven bench for design_select_sequencer.
module tb_design_select_sequencer;

  localparam int G = 4;
  localparam int R = 16;

  logic       clk;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_sel;
  logic       req_ready;
  logic [3:0] design_select;
  logic       design_n_rst;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] cur_sel;

  int errors = 0;
  int checks = 0;
  logic [3:0] cur_model = 4'd0;

  design_select_sequencer #(
    .NUM_DESIGNS  (12),
    .GUARD_CYCLES (G),
    .RESET_CYCLES (R)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_sel       (req_sel),
    .req_ready     (req_ready),
    .design_select (design_select),
    .design_n_rst  (design_n_rst),
    .busy          (busy),
    .done          (done),
    .err           (err),
    .cur_sel       (cur_sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic outs(input string tag, input int k,
                      input logic [3:0] e_sel, input logic e_nrst, input logic e_busy,
                      input logic e_done, input logic e_err, input logic [3:0] e_cur,
                      input logic e_ready);
    chk($sformatf("%s[%0d].design_select", tag, k), 8'(design_select), 8'(e_sel));
    chk($sformatf("%s[%0d].design_n_rst", tag, k), 8'(design_n_rst), 8'(e_nrst));
    chk($sformatf("%s[%0d].busy", tag, k), 8'(busy), 8'(e_busy));
    chk($sformatf("%s[%0d].done", tag, k), 8'(done), 8'(e_done));
    chk($sformatf("%s[%0d].err", tag, k), 8'(err), 8'(e_err));
    chk($sformatf("%s[%0d].cur_sel", tag, k), 8'(cur_sel), 8'(e_cur));
    chk($sformatf("%s[%0d].req_ready", tag, k), 8'(req_ready), 8'(e_ready));
  endtask

  // Expected outputs k cycles after acceptance of a valid request for tgt.
  task automatic check_phase(input string tag, input int k, input logic [3:0] tgt);
    int last;
    last = (tgt == 4'd0) ? G + 1 : G + R + 1;
    if (k <= G)
      outs(tag, k, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, cur_model, 1'b0);
    else if (k < last)
      outs(tag, k, tgt, 1'b0, 1'b1, 1'b0, 1'b0, cur_model, 1'b0);
    else
      outs(tag, k, tgt, (tgt != 4'd0), 1'b0, 1'b1, 1'b0, tgt, 1'b1);
  endtask

  // Called at a negedge; returns at the negedge of the done cycle.
  task automatic run_req(input logic [3:0] s, input string tag);
    int last;
    last = (s == 4'd0) ? G + 1 : G + R + 1;
    req_valid = 1'b1;
    req_sel   = s;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_sel   = 4'd0;
    for (int k = 1; k <= last; k++) begin
      if (k > 1) @(negedge clk);
      check_phase(tag, k, s);
    end
    cur_model = s;
  endtask

  task automatic run_bad(input logic [3:0] s, input string tag);
    req_valid = 1'b1;
    req_sel   = s;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_sel   = 4'd0;
    outs(tag, 1, cur_model, (cur_model != 4'd0), 1'b0, 1'b0, 1'b1, cur_model, 1'b1);
    @(negedge clk);
    outs(tag, 2, cur_model, (cur_model != 4'd0), 1'b0, 1'b0, 1'b0, cur_model, 1'b1);
  endtask

  // Select must never move while the design is out of reset.
  logic [3:0] prev_sel = 4'd0;
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (design_select !== prev_sel) begin
        checks++;
        if (design_n_rst !== 1'b0) begin
          errors++;
          $display("FAIL select_change_with_nrst: got n_rst=%0d expected 0 (sel %0d->%0d)",
                   design_n_rst, prev_sel, design_select);
        end
      end
    end
    prev_sel = design_select;
  end

  typedef struct {
    logic [3:0] sel;
    logic       exp_err;
    logic [3:0] exp_cur;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{sel: 4'd5,  exp_err: 1'b0, exp_cur: 4'd5};
    vecs[1] = '{sel: 4'd13, exp_err: 1'b1, exp_cur: 4'd5};
    vecs[2] = '{sel: 4'd0,  exp_err: 1'b0, exp_cur: 4'd0};
    vecs[3] = '{sel: 4'd0,  exp_err: 1'b0, exp_cur: 4'd0};
    vecs[4] = '{sel: 4'd12, exp_err: 1'b0, exp_cur: 4'd12};
    vecs[5] = '{sel: 4'd15, exp_err: 1'b1, exp_cur: 4'd12};
    vecs[6] = '{sel: 4'd1,  exp_err: 1'b0, exp_cur: 4'd1};

    req_valid = 1'b0;
    req_sel   = 4'd0;
    rst       = 1'b0;
    #1 rst = 1'b1;
    #2 outs("in_reset", 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    outs("after_reset", 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);

    // Ignored request while busy must not raise err: covered in the hold test.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_err)
        run_bad(vecs[i].sel, $sformatf("vec%0d_bad", i));
      else
        run_req(vecs[i].sel, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d.final_cur_sel", i), 8'(cur_sel), 8'(vecs[i].exp_cur));
    end

    // Hold req_valid through busy, changing req_sel mid-sequence.
    req_valid = 1'b1;
    req_sel   = 4'd9;
    @(posedge clk);
    @(negedge clk);
    for (int k = 1; k <= G + R + 1; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 10) req_sel = 4'd3;
      check_phase("hold9", k, 4'd9);
    end
    cur_model = 4'd9;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_sel   = 4'd0;
    for (int k = 1; k <= G + R + 1; k++) begin
      if (k > 1) @(negedge clk);
      check_phase("hold3", k, 4'd3);
    end
    cur_model = 4'd3;

    // Back-to-back re-select of the same design.
    run_req(4'd12, "resel12_a");
    run_req(4'd12, "resel12_b");

    // Asynchronous reset during the RESET phase toward 7.
    req_valid = 1'b1;
    req_sel   = 4'd7;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_sel   = 4'd0;
    for (int k = 1; k <= 10; k++) begin
      if (k > 1) @(negedge clk);
      check_phase("rst7", k, 4'd7);
    end
    #2 rst = 1'b1;
    #1 outs("rst7_async", 0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    cur_model = 4'd0;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      outs("rst7_after", k, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/design_select_sequencer.md
Name: design_select_sequencer

Overview:
- Upstream control stage for the 12-slot integrated-designs multiplexer; it generates that mux's design_select and per-design active-low reset.
- Accepts select requests over a valid/ready handshake and performs a glitch-free switchover in three steps: park on select 0 (all GPIO inputs), hold the new design in reset, then release.
- Guarantees that no design ever drives GPIO while its reset is asserted, and that no two designs are active in the same cycle.

Parameters:
- NUM_DESIGNS, 12, highest legal select value; 1..NUM_DESIGNS are designs, 0 is none.
- GUARD_CYCLES, 4, cycles spent parked on select 0 before a new design is applied; must be >= 1.
- RESET_CYCLES, 16, cycles the new design is held in reset with its select applied; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  select request present.
- req_sel  in  4  requested design number.
- req_ready  out  1  sequencer can accept a request.
- design_select  out  4  select value driven to the integrated-designs mux.
- design_n_rst  out  1  active-low reset for the design block.
- busy  out  1  switchover in progress.
- done  out  1  one-cycle pulse when a switchover completes.
- err  out  1  one-cycle pulse when a request is rejected.
- cur_sel  out  4  last successfully applied selection (0 = none).

Behaviour:
- Clocking and reset: single clock, clk. Reset rst is asynchronous and active-high. All outputs are registered.
- Values while rst is asserted and after its release:
  - state IDLE
  - design_select=0, design_n_rst=0, cur_sel=0
  - req_ready=1, busy=0, done=0, err=0
- States: IDLE (no design), DRAIN, RESET, ACTIVE.
- Handshake:
  - A request is accepted on a rising edge where req_valid && req_ready.
  - req_ready=1 only in IDLE and ACTIVE; it is 0 in DRAIN and RESET.
  - req_sel is sampled only at acceptance.
  - The requester must hold req_valid and req_sel until accepted.
- Invalid request (req_sel > NUM_DESIGNS):
  - Accepted, with err=1 in the following cycle.
  - No state or output change; the current design stays active.
- Valid request, accepted at edge T:
  - T+1: enter DRAIN; design_select=0, design_n_rst=0, busy=1.
  - DRAIN lasts exactly GUARD_CYCLES cycles.
  - If the target is 0: move to IDLE; done=1 on the first IDLE cycle; cur_sel=0.
  - Otherwise: move to RESET; design_select=target, design_n_rst=0, for exactly RESET_CYCLES cycles.
  - Then ACTIVE: design_n_rst=1, busy=0, cur_sel=target, done=1 on the first ACTIVE cycle only.
  - Total latency from acceptance to done is GUARD_CYCLES+RESET_CYCLES+1 cycles.
- Re-selecting the already active design runs the full sequence, i.e. a deliberate design reset. A request of 0 while in IDLE also runs DRAIN and then pulses done.
- Ordering: design_select changes only while design_n_rst=0; design_n_rst rises only after design_select has been stable for RESET_CYCLES cycles.
- Phase timer:
  - Single down-counter, width $clog2(max(GUARD_CYCLES,RESET_CYCLES)+1).
  - Loaded on each phase entry; the phase ends when the count reaches 1.
  - No wrap-around is possible.
- Simultaneous events: done and req_ready are both 1 on the first ACTIVE/IDLE cycle, so a new request may be accepted on that edge.
- Reset mid-operation: rst in any state immediately (asynchronously) forces the reset values above. The interrupted target is discarded.
- req_valid while not ready is ignored and does not raise err.

Decomposition:
- Package design_sel_pkg:
  - state enum {IDLE, DRAIN, RESET, ACTIVE}
  - SEL_W=4
  - NUM_DESIGNS_MAX=12
- Sub-module sel_phase_timer: loadable down-counter with a load value and a one-cycle expire flag, instantiated once.
- FSM, handshake and output registers live in the top module.

Test Plan:
- Release rst; req_sel=5 accepted at T -> DRAIN at T+1..T+4 with select 0; select=5 with n_rst=0 at T+5..T+20; ACTIVE at T+21 with n_rst=1, done=1, cur_sel=5.
- From ACTIVE(5), req_sel=13 -> err=1 for one cycle; select stays 5, n_rst stays 1, no busy.
- From ACTIVE(5), req_sel=0 -> 4 DRAIN cycles with select 0 and n_rst 0, then IDLE, done=1, cur_sel=0.
- req_valid held through busy with req_sel=9 then 3 changed mid-way -> only the originally accepted value 9 is applied; the second request is taken on the done cycle and the sequence restarts.
- Assert rst during the RESET phase toward 7 -> outputs immediately 0/0, state IDLE, cur_sel=0, no done pulse.
- Back-to-back re-select of 12 -> full 21-cycle sequence repeats, and n_rst never rises while select is changing.
